// File: rtl/soc_data_out.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : soc_data_out
// Description : Avalon-MM slave feeding a show-ahead FIFO that streams words
//               to the core, with STATUS/CTRL register and sticky overflow.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module soc_data_out #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   localparam int              c_aw    = $clog2(DEPTH);
   localparam int              c_cw    = c_aw + 1;
   localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

   logic [31:0]     r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_cw-1:0] r_count;
   logic            r_overflow;
   logic [31:0]     r_readdata;

   logic            w_write;
   logic            w_pop;
   logic            w_push_req;
   logic            w_push_ok;
   logic            w_flush;
   logic            w_ovf_clr;
   logic            w_ovf_set;
   logic [4:0]      w_count5;
   logic [31:0]     w_status;
   logic [31:0]     w_rd_mux;

   assign w_write    = chipselect & ~write_n;
   assign w_pop      = out_valid & out_ready;
   assign w_push_req = w_write & (address == 2'd0);
   // A full FIFO still takes a push when the head leaves in the same cycle
   assign w_push_ok  = w_push_req & ((r_count < c_depth) | w_pop);
   assign w_flush    = w_write & (address == 2'd1) & writedata[1];
   assign w_ovf_clr  = w_write & (address == 2'd1) & writedata[0];
   assign w_ovf_set  = w_push_req & ~w_push_ok;

   assign w_count5 = 5'(r_count);
   assign w_status = {24'b0, r_overflow, w_count5,
                      (r_count == c_depth), (r_count == '0)};
   assign w_rd_mux = (address == 2'd1) ? w_status : 32'b0;

   assign out_valid = (r_count != '0);
   assign out_data  = out_valid ? r_mem[r_rd_ptr] : 32'b0;
   assign readdata  = r_readdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_readdata <= 32'b0;
      end else begin
         r_readdata <= w_rd_mux;
         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
         end
         if (w_ovf_set)      r_overflow <= 1'b1;
         else if (w_ovf_clr) r_overflow <= 1'b0;
      end
   end

   // Storage needs no reset; pointers alone define which words are live
   always_ff @(posedge clk) begin
      if (w_push_ok && !reset) r_mem[r_wr_ptr] <= writedata;
   end

endmodule
`default_nettype wire

// File: tb/tb_soc_data_out.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_soc_data_out
// Description : Self-checking bench for soc_data_out against a queue model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_soc_data_out;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'b0;
   logic [31:0] readdata;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] q[$];
   logic        m_ovf = 1'b0;
   logic [31:0] m_rd  = 32'b0;

   soc_data_out #(.DEPTH(DEPTH)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_status();
      int n = q.size();
      return {24'b0, m_ovf, 5'(n), (n == DEPTH), (n == 0)};
   endfunction

   // Applies inputs, advances one clock, updates the model and checks outputs
   task automatic cycle(input logic cs, input logic wn, input logic [1:0] a,
                        input logic [31:0] wd, input logic rdy);
      logic wr, pop, ovf_set, ovf_clr;
      int   n;
      chipselect = cs; write_n = wn; address = a; writedata = wd; out_ready = rdy;
      n       = q.size();
      m_rd    = (a == 2'd1) ? model_status() : 32'b0;
      wr      = cs && !wn;
      pop     = (n != 0) && rdy;
      ovf_set = 1'b0;
      ovf_clr = wr && (a == 2'd1) && wd[0];
      @(posedge clk);
      if (wr && a == 2'd1 && wd[1]) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (wr && a == 2'd0) begin
            if (n < DEPTH || pop) q.push_back(wd);
            else ovf_set = 1'b1;
         end
      end
      if (ovf_set)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("out_data", out_data, (q.size() != 0) ? q[0] : 32'b0);
      check("readdata", readdata, m_rd);
   endtask

   task automatic push(input logic [31:0] d, input logic rdy);
      cycle(1'b1, 1'b0, 2'd0, d, rdy);
   endtask

   task automatic rd_status(input logic rdy);
      cycle(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, rdy);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_readdata", readdata, 32'd0);
      q.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      do_reset();

      // Single push reaches the head on the next cycle
      push(32'h1111_1111, 1'b0);
      check("push_head", out_data, 32'h1111_1111);
      rd_status(1'b0);
      check("status_one", readdata, 32'h0000_0004);

      // Overflow on the fifth push, then drain in order
      do_reset();
      for (int i = 0; i < 5; i++) push(32'hA0 + 32'(i), 1'b0);
      rd_status(1'b0);
      check("status_ovf_full", readdata, 32'h0000_0092);
      for (int i = 0; i < 4; i++) begin
         check("drain_order", out_data, 32'hA0 + 32'(i));
         cycle(1'b0, 1'b1, 2'd0, 32'b0, 1'b1);
      end
      check("drain_empty", 32'(out_valid), 32'd0);

      // Full FIFO accepts a push alongside a pop
      do_reset();
      for (int i = 0; i < 4; i++) push(32'hB1 + 32'(i), 1'b0);
      push(32'hB5, 1'b1);
      rd_status(1'b0);
      check("status_full_no_ovf", readdata, 32'h0000_0012);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'd0, 32'b0, 1'b1);

      // Flush beats a same-cycle pop and clears overflow
      do_reset();
      push(32'hC0, 1'b0);
      push(32'hC1, 1'b0);
      cycle(1'b1, 1'b0, 2'd1, 32'h3, 1'b1);
      check("flush_valid", 32'(out_valid), 32'd0);
      rd_status(1'b0);
      check("flush_status", readdata, 32'h0000_0001);

      // Streaming with the consumer always ready
      do_reset();
      for (int i = 0; i < 10; i++) begin
         push(32'hD0 + 32'(i), 1'b1);
         check("stream_head", out_data, 32'hD0 + 32'(i));
      end

      // Reset with words queued clears state without a clock edge
      push(32'hE0, 1'b0);
      push(32'hE1, 1'b0);
      push(32'hE2, 1'b0);
      do_reset();
      rd_status(1'b0);
      check("post_reset_status", readdata, 32'h0000_0001);
      push(32'hE5, 1'b0);
      check("post_reset_push", out_data, 32'hE5);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [1:0]  a;
         logic [31:0] wd;
         a  = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
         wd = $urandom;
         if (a == 2'd1) wd[1] = ($urandom_range(0, 7) == 0);
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a, wd,
               1'($urandom_range(0, 2) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
